// File: rtl/pc_frame_sequencer_pkg.sv
// Shared types for the PC stack frame sequencer: byte/PC types, FSM states, frame size.
// The optional stack guard is enabled by defining STACK_GUARD_EN.
package pc_frame_sequencer_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic        control_t;
  typedef logic [15:0] program_counter_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    W_HI  = 3'd1,
    W_LO  = 3'd2,
    R_LO  = 3'd3,
    R_HI  = 3'd4,
    R_CAP = 3'd5,
    FIN   = 3'd6
  } frame_state_e;

  localparam int FRAME_BYTES = 2;

  function automatic byte_t pc_byte(input program_counter_t pc, input logic hi);
    return hi ? pc[15:8] : pc[7:0];
  endfunction

endpackage

// File: rtl/pc_frame_sequencer_frame_pointer.sv
// Stack pointer and frame counter for the PC frame sequencer.
// Full/empty flags exist only when STACK_GUARD_EN is defined.
module pc_frame_sequencer_frame_pointer
  import pc_frame_sequencer_pkg::*;
#(
  parameter program_counter_t STACK_BASE   = 16'hFF00,
  parameter int               STACK_FRAMES = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output program_counter_t sp
`ifdef STACK_GUARD_EN
  ,
  output logic             full,
  output logic             empty
`endif
);

  localparam int CW = $clog2(STACK_FRAMES + 1);

  logic [CW-1:0] count;

  // sp and frame count move together; both wrap when nothing guards them
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sp    <= STACK_BASE;
      count <= {CW{1'b0}};
    end else if (inc) begin
      sp    <= sp + 16'(FRAME_BYTES);
      count <= count + CW'(1);
    end else if (dec) begin
      sp    <= sp - 16'(FRAME_BYTES);
      count <= count - CW'(1);
    end else begin
      sp    <= sp;
      count <= count;
    end
  end

`ifdef STACK_GUARD_EN
  assign full  = (count == CW'(STACK_FRAMES));
  assign empty = (count == {CW{1'b0}});
`endif

endmodule

// File: rtl/pc_frame_sequencer.sv
// Moves a 16-bit PC to/from byte-wide data memory as a 2-byte stack frame.
// Define STACK_GUARD_EN to reject pushes when full and pops when empty.
module pc_frame_sequencer
  import pc_frame_sequencer_pkg::*;
#(
  parameter program_counter_t STACK_BASE   = 16'hFF00,
  parameter int               STACK_FRAMES = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  control_t         push_req,
  input  control_t         pop_req,
  input  program_counter_t pc_in,
  input  byte_t            mem_rdata,
  output program_counter_t mem_addr,
  output byte_t            mem_wdata,
  output logic             mem_we,
  output logic             mem_re,
  output logic             busy,
  output logic             done,
  output program_counter_t pc_out,
  output logic             error
);

  frame_state_e     state;
  program_counter_t pc_latch;
  byte_t            lo_byte;
  program_counter_t sp;
  logic             sp_inc;
  logic             sp_dec;
  logic             push_ok;
  logic             pop_ok;

  assign sp_inc = (state == W_LO);
  assign sp_dec = (state == R_CAP);

`ifdef STACK_GUARD_EN
  logic full;
  logic empty;
  logic reject;
`endif

  pc_frame_sequencer_frame_pointer #(
    .STACK_BASE  (STACK_BASE),
    .STACK_FRAMES(STACK_FRAMES)
  ) u_frame_pointer (
    .clock(clock),
    .reset(reset),
    .inc  (sp_inc),
    .dec  (sp_dec),
    .sp   (sp)
`ifdef STACK_GUARD_EN
    ,
    .full (full),
    .empty(empty)
`endif
  );

  // Request arbitration in IDLE: push wins, a simultaneous pop is dropped
  always_comb begin
`ifdef STACK_GUARD_EN
    push_ok = push_req && !full;
    pop_ok  = !push_req && pop_req && !empty;
    reject  = (push_req && full) || (!push_req && pop_req && empty);
`else
    push_ok = push_req;
    pop_ok  = !push_req && pop_req;
`endif
  end

`ifndef STACK_GUARD_EN
  assign error = 1'b0;
`endif

  // Frame FSM; every output is loaded on the edge entering the state it belongs to
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc_latch  <= 16'h0000;
      lo_byte   <= 8'h00;
      mem_addr  <= STACK_BASE;
      mem_wdata <= 8'h00;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pc_out    <= 16'h0000;
`ifdef STACK_GUARD_EN
      error     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef STACK_GUARD_EN
      error <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (push_ok) begin
            state     <= W_HI;
            pc_latch  <= pc_in;
            mem_we    <= 1'b1;
            mem_addr  <= sp;
            mem_wdata <= pc_byte(pc_in, 1'b1);
            busy      <= 1'b1;
          end else if (pop_ok) begin
            state    <= R_LO;
            mem_re   <= 1'b1;
            mem_addr <= sp - 16'd1;
            busy     <= 1'b1;
          end else begin
            mem_addr <= sp;
`ifdef STACK_GUARD_EN
            error    <= reject;
`endif
          end
        end
        W_HI: begin
          state     <= W_LO;
          mem_addr  <= sp + 16'd1;
          mem_wdata <= pc_byte(pc_latch, 1'b0);
        end
        W_LO: begin
          state     <= FIN;
          mem_we    <= 1'b0;
          mem_wdata <= 8'h00;
          mem_addr  <= sp + 16'(FRAME_BYTES);
          done      <= 1'b1;
        end
        R_LO: begin
          state    <= R_HI;
          mem_addr <= sp - 16'd2;
        end
        R_HI: begin
          state    <= R_CAP;
          mem_re   <= 1'b0;
          mem_addr <= sp;
          lo_byte  <= mem_rdata;
        end
        R_CAP: begin
          state    <= FIN;
          pc_out   <= {mem_rdata, lo_byte};
          mem_addr <= sp - 16'(FRAME_BYTES);
          done     <= 1'b1;
        end
        FIN: begin
          state    <= IDLE;
          busy     <= 1'b0;
          mem_addr <= sp;
        end
        default: begin
          state     <= IDLE;
          mem_we    <= 1'b0;
          mem_re    <= 1'b0;
          busy      <= 1'b0;
          mem_addr  <= sp;
          mem_wdata <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_frame_sequencer.sv
// Self-checking bench for pc_frame_sequencer against a byte-array stack model.
// Also exercises the STACK_GUARD_EN build when that macro is defined.
module tb_pc_frame_sequencer;

  localparam logic [15:0] BASE   = 16'hFF00;
  localparam int          FRAMES = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        push_req = 1'b0;
  logic        pop_req = 1'b0;
  logic [15:0] pc_in = 16'h0000;
  logic [7:0]  mem_rdata = 8'h00;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic        busy;
  logic        done;
  logic [15:0] pc_out;
  logic        error;

  int checks = 0;
  int failures = 0;

  logic [7:0]  env_mem [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] ref_sp;
  int          ref_count;
  logic [15:0] ref_pc_out;
  logic [15:0] ref_stack [$];

  pc_frame_sequencer #(
    .STACK_BASE  (BASE),
    .STACK_FRAMES(FRAMES)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .push_req (push_req),
    .pop_req  (pop_req),
    .pc_in    (pc_in),
    .mem_rdata(mem_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .busy     (busy),
    .done     (done),
    .pc_out   (pc_out),
    .error    (error)
  );

  always #5 clock = ~clock;

  // memory: byte write on mem_we, read data one cycle after mem_re
  always @(posedge clock) begin
    if (mem_we) env_mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= env_mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
    chk({tag, "_done"}, {15'd0, done}, 16'd0);
    chk({tag, "_we"}, {15'd0, mem_we}, 16'd0);
    chk({tag, "_re"}, {15'd0, mem_re}, 16'd0);
    chk({tag, "_err"}, {15'd0, error}, 16'd0);
    chk({tag, "_addr"}, mem_addr, ref_sp);
    chk({tag, "_wdata"}, {8'd0, mem_wdata}, 16'd0);
    chk({tag, "_pcout"}, pc_out, ref_pc_out);
  endtask

  task automatic noise_drive(input bit noise);
    if (noise) begin
      push_req = 1'($urandom_range(0, 1));
      pop_req  = 1'($urandom_range(0, 1));
      pc_in    = 16'($urandom);
    end
  endtask

  // one request from IDLE; both = pop_req alongside push, noise = requests while busy
  task automatic op(input bit is_push, input logic [15:0] pc, input bit both, input bit noise);
    bit          rej;
    logic [15:0] sp0;
    logic [15:0] exp_pc;
    logic [15:0] lifo_pc;
    bit          have_lifo;
`ifdef STACK_GUARD_EN
    rej = is_push ? (ref_count == FRAMES) : (ref_count == 0);
`else
    rej = 1'b0;
`endif
    sp0 = ref_sp;
    push_req = is_push;
    pop_req  = !is_push || both;
    pc_in    = pc;
    @(negedge clock);
    push_req = 1'b0;
    pop_req  = 1'b0;
    if (rej) begin
      chk("rej_error", {15'd0, error}, 16'd1);
      chk("rej_busy", {15'd0, busy}, 16'd0);
      chk("rej_we", {15'd0, mem_we}, 16'd0);
      chk("rej_re", {15'd0, mem_re}, 16'd0);
      chk("rej_done", {15'd0, done}, 16'd0);
      @(negedge clock);
      chk_idle("rej_after");
      return;
    end
    if (is_push) begin
      chk("whi_we", {15'd0, mem_we}, 16'd1);
      chk("whi_addr", mem_addr, sp0);
      chk("whi_data", {8'd0, mem_wdata}, {8'd0, pc[15:8]});
      chk("whi_busy", {15'd0, busy}, 16'd1);
      noise_drive(noise);
      @(negedge clock);
      chk("wlo_we", {15'd0, mem_we}, 16'd1);
      chk("wlo_addr", mem_addr, sp0 + 16'd1);
      chk("wlo_data", {8'd0, mem_wdata}, {8'd0, pc[7:0]});
      chk("wlo_done", {15'd0, done}, 16'd0);
      noise_drive(noise);
      ref_mem[sp0] = pc[15:8];
      ref_mem[sp0 + 16'd1] = pc[7:0];
      ref_sp = sp0 + 16'd2;
      ref_count++;
      ref_stack.push_back(pc);
      @(negedge clock);
      chk("push_done", {15'd0, done}, 16'd1);
      chk("push_fin_we", {15'd0, mem_we}, 16'd0);
      chk("push_fin_busy", {15'd0, busy}, 16'd1);
      noise_drive(noise);
    end else begin
      exp_pc = {ref_mem[sp0 - 16'd2], ref_mem[sp0 - 16'd1]};
      have_lifo = (ref_stack.size() > 0);
      lifo_pc = have_lifo ? ref_stack.pop_back() : 16'h0000;
      chk("rlo_re", {15'd0, mem_re}, 16'd1);
      chk("rlo_addr", mem_addr, sp0 - 16'd1);
      chk("rlo_we", {15'd0, mem_we}, 16'd0);
      noise_drive(noise);
      @(negedge clock);
      chk("rhi_re", {15'd0, mem_re}, 16'd1);
      chk("rhi_addr", mem_addr, sp0 - 16'd2);
      noise_drive(noise);
      @(negedge clock);
      chk("rcap_re", {15'd0, mem_re}, 16'd0);
      chk("rcap_done", {15'd0, done}, 16'd0);
      chk("rcap_pcheld", pc_out, ref_pc_out);
      noise_drive(noise);
      ref_sp = sp0 - 16'd2;
      ref_count--;
      ref_pc_out = exp_pc;
      @(negedge clock);
      chk("pop_done", {15'd0, done}, 16'd1);
      chk("pop_pcout", pc_out, exp_pc);
      if (have_lifo) chk("pop_lifo", pc_out, lifo_pc);
      noise_drive(noise);
    end
    @(negedge clock);
    push_req = 1'b0;
    pop_req  = 1'b0;
    chk_idle("op_end");
  endtask

  initial begin
    logic [15:0] sp0;
    for (int i = 0; i < 65536; i++) begin
      env_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    ref_sp = BASE;
    ref_count = 0;
    ref_pc_out = 16'h0000;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk_idle("reset");

    op(1'b1, 16'hBEEF, 1'b0, 1'b0);
    op(1'b0, 16'h0000, 1'b0, 1'b0);
    op(1'b1, 16'h1234, 1'b0, 1'b0);
    op(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("pop_1234", pc_out, 16'h1234);

    op(1'b1, 16'h0001, 1'b0, 1'b0);
    op(1'b1, 16'h0002, 1'b0, 1'b0);
    op(1'b1, 16'h0003, 1'b0, 1'b0);
    op(1'b0, 16'h0000, 1'b0, 1'b0);
    op(1'b0, 16'h0000, 1'b0, 1'b0);
    op(1'b0, 16'h0000, 1'b0, 1'b0);

    // stack now empty: guard rejects, otherwise sp wraps below the base
    op(1'b0, 16'h0000, 1'b0, 1'b0);

    op(1'b1, 16'hC0DE, 1'b1, 1'b1);
    op(1'b0, 16'h0000, 1'b0, 1'b1);

    // reset during W_LO
    sp0 = ref_sp;
    push_req = 1'b1;
    pc_in = 16'hA55A;
    @(negedge clock);
    push_req = 1'b0;
    @(negedge clock);
    chk("rst_pre_we", {15'd0, mem_we}, 16'd1);
    reset = 1'b1;
    #1;
    chk("rst_we_drop", {15'd0, mem_we}, 16'd0);
    chk("rst_busy_drop", {15'd0, busy}, 16'd0);
    ref_mem[sp0] = 8'hA5;
    ref_sp = BASE;
    ref_count = 0;
    ref_pc_out = 16'h0000;
    ref_stack.delete();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk_idle("post_rst");

    for (int n = 0; n < 40; n++) begin
      op(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
